// File: rtl/uart_defs_pkg.sv
// Shared definitions for the UART transmit path.
//   DATA_BITS_MAX  : character width, matches the TX core data width
//   launch_state_e : launcher FSM state encoding
//   get_width()    : bits needed to index a given number of entries
package uart_defs;

  localparam int unsigned DATA_BITS_MAX = 8;

  typedef enum logic [1:0] {
    LIdle  = 2'd0,
    LStart = 2'd1,
    LWait  = 2'd2
  } launch_state_e;

  function automatic int unsigned get_width(input int unsigned entries);
    return (entries <= 1) ? 1 : $clog2(entries);
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with flush and overflow reporting.
//   clk, rst         : clock, synchronous active-high reset
//   flush            : empty the FIFO; beats a same-cycle write or pop
//   wr_en, wr_data   : write port; a write while full is dropped
//   pop, rd_data     : advance head; rd_data is the head entry (combinational)
//   full, empty      : registered status
//   count            : registered occupancy 0..DEPTH
//   overflow         : one-cycle pulse after a dropped write
module fifo_sync #(
  parameter int unsigned DEPTH_WIDTH = 4,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_WIDTH:0]  count,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0]   CountFull = (DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0]   CountOne  = 1;
  localparam logic [DEPTH_WIDTH-1:0] PtrOne    = 1;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_WIDTH:0]   count_q, count_d;
  logic                   full_q, empty_q, overflow_q;
  logic                   push, pop_ok;

  // Full/empty are judged on registered values, so a write while full is
  // dropped even if a pop happens in the same cycle.
  assign push   = wr_en && !full_q && !flush;
  assign pop_ok = pop && !empty_q && !flush;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop_ok) begin
      count_d = count_q + CountOne;
    end else if (pop_ok && !push) begin
      count_d = count_q - CountOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push)   wr_ptr_q <= wr_ptr_q + PtrOne;
        if (pop_ok) rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      count_q    <= count_d;
      full_q     <= (count_d == CountFull);
      empty_q    <= (count_d == '0);
      overflow_q <= wr_en && full_q && !flush;
    end
  end

  // Storage needs no reset; occupancy tracking decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit buffer feeding the UART TX core one character at a time.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drop queued characters (in-flight one completes)
//   wr_en, wr_data    : character write port
//   full, empty       : FIFO status
//   count             : FIFO occupancy
//   overflow          : pulse after a write dropped because full
//   idle              : nothing queued, launcher idle, core not busy
//   tx_en, tx_data    : start pulse and character to the TX core
//   tx_busy, tx_ack   : TX core busy flag and character-sent pulse
module uart_tx_buffer #(
  parameter int unsigned DEPTH_WIDTH   = 4,
  parameter int unsigned DATA_BITS_MAX = uart_defs::DATA_BITS_MAX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_BITS_MAX-1:0] wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [DEPTH_WIDTH:0]     count,
  output logic                     overflow,
  output logic                     idle,
  output logic                     tx_en,
  output logic [DATA_BITS_MAX-1:0] tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_ack
);

  import uart_defs::*;

  launch_state_e            state_q;
  logic                     tx_en_q, idle_q, busy_q, pop;
  logic [DATA_BITS_MAX-1:0] tx_data_q, head_data;

  fifo_sync #(
    .DEPTH_WIDTH (DEPTH_WIDTH),
    .DATA_WIDTH  (DATA_BITS_MAX)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .pop      (pop),
    .rd_data  (head_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  // busy_q holds off the launch for one extra cycle after the core's busy
  // falls, giving the 3-cycle ack-to-next-en spacing and keeping tx_en clear
  // of the core's busy window.
  assign pop = (state_q == LIdle) && !empty && !tx_busy && !busy_q && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LIdle;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      busy_q  <= tx_busy;
      idle_q  <= empty && (state_q == LIdle) && !tx_busy;
      tx_en_q <= 1'b0;
      unique case (state_q)
        LIdle: begin
          if (pop) begin
            tx_data_q <= head_data;
            tx_en_q   <= 1'b1;
            state_q   <= LStart;
          end
        end
        LStart:  state_q <= LWait;
        LWait:   if (tx_ack) state_q <= LIdle;
        default: state_q <= LIdle;
      endcase
    end
  end

  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;
  assign idle    = idle_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
module tb_uart_tx_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, idle, tx_en;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_ack = 1'b0;

  // TX core model: busy the cycle after en, ack after ack_delay+1 busy cycles,
  // busy falls the cycle after ack. core_stall forces busy externally.
  logic       model_busy = 1'b0;
  logic       core_active = 1'b0;
  logic       core_stall = 1'b0;
  int         core_cnt = 0;
  int         ack_delay = 19;

  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] sent_q[$];
  int         ack_total = 0;
  logic       inflight = 1'b0;
  logic [7:0] inflight_data = 8'h00;
  logic       prev_en = 1'b0;

  always #5 clk = ~clk;
  assign tx_busy = model_busy | core_stall;

  uart_tx_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .idle     (idle),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_ack   (tx_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    tx_ack <= 1'b0;
    if (core_active) begin
      if (tx_ack) begin
        model_busy  <= 1'b0;
        core_active <= 1'b0;
      end else if (core_cnt >= ack_delay) begin
        tx_ack <= 1'b1;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end else if (tx_en) begin
      core_active <= 1'b1;
      model_busy  <= 1'b1;
      core_cnt    <= 0;
    end
  end

  // Output monitor, runs on the falling edge ahead of the stimulus steps.
  always @(negedge clk) begin
    if (tx_ack) begin
      ack_total++;
      if (inflight) check("data_stable_at_ack", tx_data, inflight_data);
      inflight = 1'b0;
    end
    if (tx_en) begin
      check("en_while_busy", tx_busy, 1'b0);
      check("en_one_cycle", prev_en, 1'b0);
      sent_q.push_back(tx_data);
      inflight      = 1'b1;
      inflight_data = tx_data;
    end
    prev_en = tx_en;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_sent(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (sent_q.size() < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, sent_q.size(), target);
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int k, base;
    k    = 0;
    base = ack_total;
    while (ack_total == base && k < budget) begin
      tick();
      k++;
    end
    check(tag, ack_total, base + 1);
  endtask

  task automatic compare_seq(input string tag, input int base, input logic [7:0] exp[$]);
    int n;
    n = sent_q.size() - base;
    check({tag, "_len"}, n, exp.size());
    for (int i = 0; i < exp.size() && i < n; i++) begin
      check({tag, "_data"}, sent_q[base + i], exp[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp[$];
    logic [7:0] first;
    int         base;
    int         guard;

    // Reset values
    tick();
    tick();
    check("rst_full", full, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, 5'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    rst = 1'b0;
    tick();

    // Single character: empty drops in cycle 1, tx_en in cycle 2
    ack_delay = 19;
    wr_en = 1'b1;
    wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    check("single_empty_c1", empty, 1'b0);
    check("single_en_c1", tx_en, 1'b0);
    tick();
    check("single_en_c2", tx_en, 1'b1);
    check("single_data_c2", tx_data, 8'hA5);
    tick();
    check("single_en_c3", tx_en, 1'b0);
    wait_ack("single_ack", 100);
    tick();
    check("single_idle_ack1", idle, 1'b0);
    tick();
    check("single_idle_ack2", idle, 1'b1);

    // Burst of 16 into a stalled core, 17th write overflows
    ack_delay = 3;
    base = sent_q.size();
    exp.delete();
    core_stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      exp.push_back(8'(i));
      tick();
    end
    check("burst_full", full, 1'b1);
    check("burst_count", count, 5'd16);
    check("burst_no_ovf_yet", overflow, 1'b0);
    wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    check("burst_ovf_pulse", overflow, 1'b1);
    check("burst_count_kept", count, 5'd16);
    tick();
    check("burst_ovf_end", overflow, 1'b0);
    core_stall = 1'b0;
    wait_sent("burst_drain", base + 16, 800);
    repeat (40) tick();
    compare_seq("burst_order", base, exp);
    check("burst_empty", empty, 1'b1);
    check("burst_idle", idle, 1'b1);

    // Push and pop in the same cycle at count 5
    base = sent_q.size();
    exp.delete();
    core_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h10 + i);
      exp.push_back(8'(8'h10 + i));
      tick();
    end
    wr_en = 1'b0;
    tick();
    check("pp_count_before", count, 5'd5);
    core_stall = 1'b0;
    tick();
    check("pp_count_hold", count, 5'd5);
    check("pp_no_en_yet", tx_en, 1'b0);
    wr_en = 1'b1;
    wr_data = 8'h20;
    exp.push_back(8'h20);
    tick();
    wr_en = 1'b0;
    check("pp_count_same", count, 5'd5);
    check("pp_en", tx_en, 1'b1);
    check("pp_head", tx_data, 8'h10);
    wait_sent("pp_drain", base + 6, 400);
    repeat (10) tick();
    compare_seq("pp_order", base, exp);

    // 40 random characters with random gaps, pointers wrap
    base = sent_q.size();
    exp.delete();
    for (int i = 0; i < 40; i++) begin
      guard = 0;
      while ((i - (sent_q.size() - base)) >= 12 && guard < 500) begin
        tick();
        guard++;
      end
      wr_en = 1'b1;
      wr_data = 8'($urandom_range(0, 255));
      exp.push_back(wr_data);
      tick();
      wr_en = 1'b0;
      repeat ($urandom_range(0, 5)) tick();
    end
    wait_sent("wrap_drain", base + 40, 2000);
    repeat (10) tick();
    compare_seq("wrap_order", base, exp);

    // Flush during L_WAIT with 6 queued
    ack_delay = 15;
    base = sent_q.size();
    first = 8'($urandom_range(0, 255));
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1;
      wr_data = (i == 0) ? first : 8'($urandom_range(0, 255));
      tick();
    end
    check("flush_count_before", count, 5'd6);
    guard = ack_total;
    flush = 1'b1;
    wr_data = 8'h77;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    check("flush_count", count, 5'd0);
    check("flush_empty", empty, 1'b1);
    check("flush_no_ovf", overflow, 1'b0);
    wait_ack("flush_ack", 200);
    repeat (30) tick();
    exp.delete();
    exp.push_back(first);
    compare_seq("flush_sent", base, exp);
    check("flush_one_ack", ack_total - guard, 1);
    check("flush_empty_end", empty, 1'b1);
    check("flush_idle_end", idle, 1'b1);

    // Reset mid-L_WAIT with 3 queued
    base = sent_q.size();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h40 + i);
      tick();
    end
    check("rstw_count_before", count, 5'd3);
    wr_en = 1'b0;
    rst = 1'b1;
    inflight = 1'b0;
    tick();
    rst = 1'b0;
    check("rstw_tx_en", tx_en, 1'b0);
    check("rstw_tx_data", tx_data, 8'h00);
    check("rstw_empty", empty, 1'b1);
    check("rstw_count", count, 5'd0);
    check("rstw_idle", idle, 1'b1);
    check("rstw_full", full, 1'b0);
    repeat (40) tick();
    check("rstw_sent", sent_q.size(), base + 1);
    check("rstw_empty_end", empty, 1'b1);
    check("rstw_count_end", count, 5'd0);
    check("rstw_idle_end", idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Transmit-side buffer directly upstream of the UART TX core.
- Accepts bytes from the bus/register interface into a synchronous FIFO.
- A launcher FSM issues one character at a time to the core via its en/data/busy/ack handshake.
- Decouples software writes from the serial bit rate; reports fill level, full/empty, overflow and an all-sent idle flag.

Parameters:
- DEPTH_WIDTH, 4, log2 of FIFO depth (default depth = 16 entries).
- DATA_BITS_MAX, 8, character width; matches TX core data width.

Ports:
- clk  input  1  main clock.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  discard all queued (not yet launched) characters.
- wr_en  input  1  write strobe, one character per cycle.
- wr_data  input  DATA_BITS_MAX  character to queue.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  DEPTH_WIDTH+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse when a write is dropped.
- idle  output  1  nothing queued, nothing launched, core not busy.
- tx_en  output  1  start pulse to TX core.
- tx_data  output  DATA_BITS_MAX  character to TX core; valid while tx_en=1.
- tx_busy  input  1  TX core busy flag.
- tx_ack  input  1  TX core one-cycle "character sent" pulse.

Behaviour:
- Reset values: full=0, empty=1, count=0, overflow=0, idle=1, tx_en=0, tx_data=0.
  - FIFO pointers are zeroed; launcher goes to L_IDLE.
  - Reset mid-transmission abandons the character in flight without waiting for tx_ack.
- FIFO write rules:
  - wr_en=1 and full=0: store wr_data at the write pointer; count+1 at the next edge.
  - wr_en=1 and full=1: data is dropped; overflow=1 for the next cycle; FIFO unchanged.
  - full is judged on the registered value. A write coinciding with a pop while full is still dropped.
- Pointers are DEPTH_WIDTH bits and wrap naturally modulo DEPTH.
- count is the registered occupancy. Simultaneous push and pop leaves count unchanged.
- Launcher FSM:
  - L_IDLE: if empty=0 and tx_busy=0, pop the head, register it into tx_data, and go to L_START.
  - L_START: tx_en=1 for exactly one cycle; go to L_WAIT.
  - L_WAIT: hold tx_data. On tx_ack=1, go to L_IDLE. tx_ack while in L_IDLE/L_START is ignored.
- tx_en is never asserted while tx_busy=1. The core samples data on its en cycle and raises busy on the next cycle.
- tx_data stays stable from L_START through L_WAIT.
- Latency:
  - wr_en in cycle 0 into an empty, idle block gives empty=0 in cycle 1, tx_en=1 in cycle 2.
  - Back-to-back characters: the next tx_en is 3 cycles after the tx_ack cycle.
    - Cycle +1: the core's busy falls.
    - Cycle +2: pop.
    - Cycle +3: tx_en.
- Flush:
  - Clears the FIFO: count=0 and empty=1 on the next edge.
  - A character already in L_START/L_WAIT is completed normally.
  - flush has priority over a same-cycle wr_en (that write is discarded, no overflow pulse) and over a same-cycle pop (no launch).
- idle = empty and launcher in L_IDLE and tx_busy=0 (registered).
- Line-format settings (data_type, stop_type, check) belong to the core. This block passes data untouched; upper bits are ignored by the core for short formats.

Decomposition:
- Shared package/header `uart_defs`:
  - DATA_BITS_MAX.
  - Launcher state encodings L_IDLE=0, L_START=1, L_WAIT=2.
  - GET_WIDTH function, already present in function.vh.
- One sub-module, `fifo_sync`:
  - Parameterised synchronous FIFO with write, pop, flush, full, empty, count.
  - Registered outputs; read data is combinational from the head entry.
- The launcher FSM lives in uart_tx_buffer.

Test Plan:
- Single write 0xA5 into an empty buffer, with a core model acking 20 cycles after busy:
  - tx_en pulse in cycle 2 with tx_data=0xA5, exactly one cycle wide.
  - idle=1 two cycles after tx_ack.
- Burst of 16 writes (0x00..0x0F) with the core stalled busy:
  - full=1, count=16.
  - A 17th write 0xFF gives an overflow pulse and is never transmitted.
  - Output order is 0x00..0x0F.
- Push and pop in the same cycle at count=5: count stays 5; the written data appears in order after the existing entries.
- Pointer wrap: 40 characters streamed with random write gaps; all 40 emerge in order, no loss, no duplicates.
- Flush during L_WAIT with 6 queued:
  - The in-flight character still completes, with one tx_ack.
  - No further tx_en; empty=1; the same-cycle write is discarded without an overflow pulse.
- rst asserted mid-L_WAIT with 3 queued: next cycle tx_en=0, empty=1, count=0, idle=1; a late tx_ack is ignored.
